// File: rtl/ones_run_accum.sv
`default_nettype none
// ============================================================================
//  Module   : ones_run_accum
//  Purpose  : Longest run of consecutive 1s across a multi-byte operand that
//             streams in one byte per cycle, MSB byte first. Runs crossing
//             byte boundaries are merged. Valid/ready on input and output.
//  Options  : ONES_RUN_POS_EN adds the max_pos port (MSB index of the run).
//  Revision : 1.0  initial release
// ============================================================================
module ones_run_accum #(
    parameter int WORD_BYTES = 4,
    parameter int RW         = $clog2(8*WORD_BYTES+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] max_run,
    output logic          all_ones
`ifdef ONES_RUN_POS_EN
    ,
    output logic [RW-1:0] max_pos
`endif
);

    localparam int         C_W     = 8*WORD_BYTES;
    localparam int         C_CW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ACCUM = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [C_CW-1:0] r_cnt;
    logic [RW-1:0]   r_cur;
    logic [RW-1:0]   r_best;

    logic            w_accept;
    logic            w_last;
    logic            w_full;
    logic [RW-1:0]   w_lead;
    logic [RW-1:0]   w_trail;
    logic [RW-1:0]   w_imax;
    logic [RW-1:0]   w_cand;
    logic [RW-1:0]   w_best_nxt;
    logic [RW-1:0]   w_cur_nxt;

`ifdef ONES_RUN_POS_EN
    logic [RW-1:0]   r_pos;
    logic [RW-1:0]   r_start;
    logic [2:0]      w_imax_msb;
    logic [RW-1:0]   w_base;
    logic [RW-1:0]   w_cand_start;
    logic [RW-1:0]   w_start_nxt;
    logic [RW-1:0]   w_pos_nxt;
`endif

    // Handshake and result outputs are decoded from registered state only
    assign in_ready  = (r_state != C_DONE);
    assign out_valid = (r_state == C_DONE);
    assign max_run   = r_best;
    assign all_ones  = (r_best == RW'(C_W));
`ifdef ONES_RUN_POS_EN
    assign max_pos   = r_pos;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == C_CW'(WORD_BYTES-1));
    assign w_full   = &in_byte;

    // Per-byte scan: leading ones, trailing ones, longest internal run
    always_comb begin : p_byte_scan
        int   v_lead;
        int   v_trail;
        int   v_run;
        int   v_imax;
        int   v_imax_msb;
        logic v_lead_on;
        logic v_trail_on;
        v_lead     = 0;
        v_trail    = 0;
        v_run      = 0;
        v_imax     = 0;
        v_imax_msb = 0;
        v_lead_on  = 1'b1;
        v_trail_on = 1'b1;
        // Scanning MSB first with a strict compare keeps the earliest run on ties
        for (int i = 7; i >= 0; i--) begin
            if (v_lead_on && in_byte[i]) v_lead = v_lead + 1;
            else                         v_lead_on = 1'b0;
            if (in_byte[i]) v_run = v_run + 1;
            else            v_run = 0;
            if (v_run > v_imax) begin
                v_imax     = v_run;
                v_imax_msb = i + v_run - 1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (v_trail_on && in_byte[i]) v_trail = v_trail + 1;
            else                          v_trail_on = 1'b0;
        end
        w_lead  = RW'(v_lead);
        w_trail = RW'(v_trail);
        w_imax  = RW'(v_imax);
`ifdef ONES_RUN_POS_EN
        w_imax_msb = 3'(v_imax_msb);
`endif
    end

    assign w_cand    = r_cur + w_lead;
    assign w_cur_nxt = w_full ? (r_cur + RW'(8)) : w_trail;

`ifdef ONES_RUN_POS_EN
    // Word bit index of bit 0 of the byte currently offered
    assign w_base       = RW'((WORD_BYTES - 1 - int'(r_cnt)) * 8);
    // An open run either continues from earlier bytes or starts at bit 7 here
    assign w_cand_start = (r_cur != '0) ? r_start : (w_base + RW'(7));
    assign w_start_nxt  = w_full            ? w_cand_start :
                          (w_trail != '0)   ? (w_base + w_trail - RW'(1)) : '0;
`endif

    // Best-run update; cand is tried before imax so the earlier run wins ties
    always_comb begin
        w_best_nxt = r_best;
`ifdef ONES_RUN_POS_EN
        w_pos_nxt  = r_pos;
`endif
        if (w_cand > w_best_nxt) begin
            w_best_nxt = w_cand;
`ifdef ONES_RUN_POS_EN
            w_pos_nxt  = w_cand_start;
`endif
        end
        if (w_imax > w_best_nxt) begin
            w_best_nxt = w_imax;
`ifdef ONES_RUN_POS_EN
            w_pos_nxt  = w_base + RW'(w_imax_msb);
`endif
        end
    end

    // Control FSM and run accumulators; everything clears on entry to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            r_best  <= '0;
`ifdef ONES_RUN_POS_EN
            r_pos   <= '0;
            r_start <= '0;
`endif
        end else begin
            case (r_state)
                C_IDLE, C_ACCUM: begin
                    if (w_accept) begin
                        r_best <= w_best_nxt;
                        r_cur  <= w_cur_nxt;
`ifdef ONES_RUN_POS_EN
                        r_pos   <= w_pos_nxt;
                        r_start <= w_start_nxt;
`endif
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= C_DONE;
                        end else begin
                            r_cnt   <= r_cnt + C_CW'(1);
                            r_state <= C_ACCUM;
                        end
                    end
                end
                C_DONE: begin
                    if (out_ready) begin
                        r_state <= C_IDLE;
                        r_cnt   <= '0;
                        r_cur   <= '0;
                        r_best  <= '0;
`ifdef ONES_RUN_POS_EN
                        r_pos   <= '0;
                        r_start <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ones_run_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ones_run_accum
//  Purpose  : Self-checking bench for ones_run_accum (WORD_BYTES = 4).
//             Directed vector table, hand-written corner sequences and
//             random words checked against a bit-scan reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ones_run_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] max_run;
    logic       all_ones;
`ifdef ONES_RUN_POS_EN
    logic [5:0] max_pos;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] word;
        int          run;
        int          pos;
    } vec_t;

    vec_t tbl[6];

    ones_run_accum #(.WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_run   (max_run),
        .all_ones  (all_ones)
`ifdef ONES_RUN_POS_EN
        ,
        .max_pos   (max_pos)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: longest run of 1s over the 32-bit word, MSB index of the first such run
    function automatic void model(input logic [31:0] w, output int run, output int pos);
        int cur;
        cur = 0;
        run = 0;
        pos = 0;
        for (int i = 31; i >= 0; i--) begin
            cur = w[i] ? cur + 1 : 0;
            if (cur > run) begin
                run = cur;
                pos = i + cur - 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte after an idle gap, wait (bounded) for it to be accepted
    task automatic push_byte(input logic [7:0] b, input int gap);
        bit got;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_byte  = b;
        got      = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            if (in_ready === 1'b1) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic push_word(input logic [31:0] w, input int gap_max);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[31-8*k -: 8];
            if (k == 3) chk("pre_last_out_valid", out_valid, 1'b0);
            push_byte(b, (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        end
        chk("latency_out_valid", out_valid, 1'b1);
    endtask

    task automatic run_word(input logic [31:0] w, input int exp_run, input int exp_pos,
                            input int gap_max, input int hold);
        push_word(w, gap_max);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_max_run", max_run, exp_run);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        chk("max_run", max_run, exp_run);
        chk("all_ones", all_ones, (exp_run == 32));
`ifdef ONES_RUN_POS_EN
        chk("max_pos", max_pos, exp_pos);
`else
        if (exp_pos < 0) chk("exp_pos_range", exp_pos, 0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 1'b0);
        chk("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r_run;
        int          r_pos;
        logic [31:0] w;

        tbl[0] = '{32'h0000_0000,  0,  0};
        tbl[1] = '{32'hFFFF_FFFF, 32, 31};
        tbl[2] = '{32'h0003_FFC1, 12, 17};
        tbl[3] = '{32'hF0F0_F0F0,  4, 31};
        tbl[4] = '{32'h0180_0000,  2, 24};
        tbl[5] = '{32'h0000_00FF,  8,  7};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_max_run", max_run, 0);
        chk("rst_all_ones", all_ones, 1'b0);
`ifdef ONES_RUN_POS_EN
        chk("rst_max_pos", max_pos, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 6; i++)
            run_word(tbl[i].word, tbl[i].run, tbl[i].pos, 0, 0);

        // Backpressure: result held, offered bytes must not be consumed
        push_word(32'hF0F0_F0F0, 0);
        in_valid  = 1'b1;
        in_byte   = 8'hFF;
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_max_run", max_run, 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", out_valid, 1'b0);
        run_word(32'h0000_00FF, 8, 7, 0, 0);

        // Reset mid-word discards the partial word
        push_byte(8'hFF, 0);
        push_byte(8'hFF, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_max_run", max_run, 0);
        run_word(32'h0000_0003, 2, 1, 0, 0);

        // Reset while the result is pending
        push_word(32'hFFFF_FFFF, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("donerst_out_valid", out_valid, 1'b0);
        chk("donerst_max_run", max_run, 0);
        run_word(32'h8000_0001, 1, 31, 1, 1);

        // Random words with random gaps and result stalls
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(2, 0))
                0:       w = $urandom;
                1:       w = $urandom | $urandom;
                default: w = ((32'hFFFF_FFFF >> $urandom_range(31, 0)) << $urandom_range(31, 0))
                             ^ (32'h1 << $urandom_range(31, 0));
            endcase
            model(w, r_run, r_pos);
            run_word(w, r_run, r_pos, 2, int'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ones_run_accum.md
# ones_run_accum

Sequential aggregator that computes the longest run of consecutive 1s across a multi-byte ALU operand. The operand streams in one byte per cycle, MSB byte first. Runs that cross byte boundaries are merged. The block sits directly downstream of the 8-bit ones-string encoder stage and extends that stage's per-byte maximum-run result to full operand width for the 32-bit ALU test path. It has valid/ready handshakes on both input and output.

## Interface
- WORD_BYTES, 4: bytes per operand; word width W = 8*WORD_BYTES.
- RW, $clog2(8*WORD_BYTES+1): result width (6 when WORD_BYTES=4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_byte  in  8  operand byte, MSB byte of the word first.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- max_run  out  RW  longest run of 1s in the word (0..W).
- all_ones  out  1  asserted when max_run == W.
- max_pos  out  RW  only with ONES_RUN_POS_EN: word bit index of the MSB of the longest run.

## Operation
- Bit numbering: the first byte occupies word bits W-1..W-8; the last byte occupies bits 7..0.
- States:
  - IDLE: no bytes held. in_ready=1.
  - ACCUM: 1..WORD_BYTES-1 bytes accepted. in_ready=1.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE→ACCUM on the first accept (IDLE→DONE directly if WORD_BYTES=1).
  - ACCUM→DONE on accepting byte index WORD_BYTES-1.
  - DONE→IDLE on out_valid&&out_ready.
- A byte is accepted when in_valid && in_ready. Byte counter width is $clog2(WORD_BYTES).
- Per accepted byte b, compute combinationally:
  - lead = count of 1s from bit 7 downward.
  - trail = count of 1s from bit 0 upward.
  - imax = longest run fully inside b.
  - full = (b==8'hFF).
- Registered state is cur (open run ending at the last accepted bit) and best; both are RW wide. On accept:
  - cand = cur + lead.
  - best_next = max(best, cand, imax). A strict greater-than compare updates best, so the earliest (most significant) run wins ties.
  - cur_next = full ? cur+8 : trail.
- Arithmetic cannot overflow, because cur + 8 ≤ W.
- best and cur clear to 0 on entry to IDLE, meaning on the result handshake or on reset.
- max_run = best and all_ones = (best==W), both held stable throughout DONE.
- in_valid is ignored in DONE. Bytes are never dropped: they wait until in_ready is high.

## Timing
- Reset values: out_valid=0, max_run=0, all_ones=0, max_pos=0, in_ready=1, state=IDLE, counter=0.
- Latency: out_valid rises the cycle after the last byte is accepted.
- Minimum period is WORD_BYTES+1 cycles per word. The accept of the next word's first byte can occur at the earliest in the cycle after the result handshake.
- When out_ready is held low, outputs stay constant and in_ready stays 0 indefinitely.
- Reset mid-word or in DONE: the partial word is discarded, out_valid drops in the next cycle, and the next accepted byte starts a fresh word.
- There is no combinational path from in_valid or in_byte to any output. in_ready depends on state only.

## Configuration
- ONES_RUN_POS_EN defined:
  - max_pos port is present.
  - A registered pos tracks the MSB index of best.
  - A start-index register records the MSB index of the open run cur. The start index is set at a run's first 1 and kept across full bytes.
  - On a strict improvement by cand, pos takes the open run's start index. On a strict improvement by imax, pos takes the index of that internal run's MSB.
  - max_pos=0 when max_run=0. Reset value is 0.
- Not defined: no max_pos port and no position logic. All other behaviour is identical.

## Test plan
- Word 0x00000000 → max_run=0, all_ones=0, max_pos=0; out_valid exactly 1 cycle after the 4th accept.
- Word 0xFFFFFFFF → max_run=32, all_ones=1, max_pos=31.
- Word 0x0003FFC1 (bytes 00,03,FF,C1) → max_run=12, max_pos=17; checks that a run spans three bytes.
- Word 0xF0F0F0F0 → max_run=4, max_pos=31 (tie resolves to the earliest run). Then word 0x01800000 → max_run=2, max_pos=24.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and in_byte=8'hFF → in_ready=0, max_run stable, no byte consumed. Raising out_ready gives DONE→IDLE, and the next word 0x000000FF yields 8.
- Reset with rst_n=0 after 2 bytes of 0xFFFF.... Then the word 0x00000003 → max_run=2; no carry-over from the aborted word.
